// File: rtl/wb_arbiter_if.sv
// Writeback arbitration bus: per-unit result requests in, one registered result out.
// The slave modport is the arbiter side; the master modport is the units/consumer side.
interface wb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 3,
  parameter int PRD_W     = 7
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*PRD_W-1:0]     req_rd;
  logic                         mispredict;
  logic [(1<<ROB_IDX_W)-1:0]    flush_mask;
  logic                         wb_ready;
  logic                         WB_out_valid;
  logic [DATA_W-1:0]            WB_out_data;
  logic [ROB_IDX_W-1:0]         WB_out_rob_idx;
  logic [PRD_W-1:0]             WB_out_rd;
  logic [15:0]                  conflict_cnt;

  modport slave (
    input  req_valid, req_data, req_rob_idx, req_rd, mispredict, flush_mask, wb_ready,
    output req_ready, WB_out_valid, WB_out_data, WB_out_rob_idx, WB_out_rd, conflict_cnt
  );

  modport master (
    output req_valid, req_data, req_rob_idx, req_rd, mispredict, flush_mask, wb_ready,
    input  req_ready, WB_out_valid, WB_out_data, WB_out_rob_idx, WB_out_rd, conflict_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback bus arbiter with starvation escalation and mispredict squash.
// One winner per cycle is latched into the WB output register feeding ROB/Rename/IS.
module wb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 32,
  parameter int ROB_IDX_W    = 3,
  parameter int PRD_W        = 7,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     starve_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   flush;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   starved;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     idx;
  logic                 any_grant;
  logic                 out_flush;
  logic                 load_en;
  logic                 multi_elig;
  logic                 wb_valid;
  logic [DATA_W-1:0]    wb_data;
  logic [ROB_IDX_W-1:0] wb_rob_idx;
  logic [PRD_W-1:0]     wb_rd;
  logic [15:0]          conflict_q;
  int                   n_elig;
  int                   s;

  always_comb begin
    flush   = '0;
    elig    = '0;
    starved = '0;
    n_elig  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      flush[i]   = bus.mispredict && bus.flush_mask[bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]];
      elig[i]    = bus.req_valid[i] && !flush[i];
      starved[i] = elig[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
      n_elig     = n_elig + (elig[i] ? 1 : 0);
    end
    multi_elig = (n_elig >= 2);
  end

  assign out_flush = bus.mispredict && wb_valid && bus.flush_mask[wb_rob_idx];
  assign load_en   = !wb_valid || bus.wb_ready || out_flush;

  // Loops run high-to-low so the last hit is the lowest index / nearest to rr_ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    s         = 0;
    if (!rst && load_en) begin
      if (|starved) begin
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          if (starved[i]) begin
            grant_idx = PTR_W'(i);
            any_grant = 1'b1;
          end
        end
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          s = int'(rr_ptr) + k;
          if (s >= NUM_REQ) s = s - NUM_REQ;
          idx = PTR_W'(s);
          if (elig[idx]) begin
            grant_idx = idx;
            any_grant = 1'b1;
          end
        end
      end
      if (any_grant) grant[grant_idx] = 1'b1;
    end
  end

  // Flushed requests are drained immediately so they never reach the WB register.
  assign bus.req_ready = rst ? '0 : (grant | (bus.req_valid & flush));

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rob_idx <= '0;
      wb_rd      <= '0;
      rr_ptr     <= '0;
      conflict_q <= '0;
    end else begin
      if (any_grant) begin
        wb_valid   <= 1'b1;
        wb_data    <= bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
        wb_rob_idx <= bus.req_rob_idx[int'(grant_idx)*ROB_IDX_W +: ROB_IDX_W];
        wb_rd      <= bus.req_rd[int'(grant_idx)*PRD_W +: PRD_W];
        rr_ptr     <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end else if (load_en) begin
        wb_valid <= 1'b0;
      end
      if (load_en && multi_elig && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end
  end

  // Waiting counts keep accruing under backpressure, which is what escalates them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || grant[i] || !elig[i]) starve_cnt[i] <= '0;
      else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
    end
  end

  assign bus.WB_out_valid   = wb_valid;
  assign bus.WB_out_data    = wb_data;
  assign bus.WB_out_rob_idx = wb_rob_idx;
  assign bus.WB_out_rd      = wb_rd;
  assign bus.conflict_cnt   = conflict_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected WB results are queued when a grant is expected
// and popped when the registered output should show them.
module tb_wb_arbiter;
  typedef struct {
    logic [31:0] data;
    logic [2:0]  rob;
    logic [6:0]  rd;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wb_exp_t sb [$];
  wb_exp_t last;
  logic [31:0] u_data [4];
  logic [2:0]  u_rob  [4];
  logic [6:0]  u_rd   [4];
  logic [3:0]  pending;

  wb_arbiter_if #(.NUM_REQ(4), .DATA_W(32), .ROB_IDX_W(3), .PRD_W(7)) bus ();

  wb_arbiter #(.NUM_REQ(4), .DATA_W(32), .ROB_IDX_W(3), .PRD_W(7), .STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] rob, input logic [6:0] rd);
    u_data[i] = d;
    u_rob[i]  = rob;
    u_rd[i]   = rd;
    bus.req_data[i*32 +: 32]  = d;
    bus.req_rob_idx[i*3 +: 3] = rob;
    bus.req_rd[i*7 +: 7]      = rd;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 4; i++)
      set_req(i, 32'hA000_0000 + 32'h0111_1111 * (i + 1), 3'(i), 7'(20 + i));
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic wbr, input logic mis,
                                input logic [7:0] mask);
    bus.req_valid  = valid;
    bus.wb_ready   = wbr;
    bus.mispredict = mis;
    bus.flush_mask = mask;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_unit(input int i);
    wb_exp_t e;
    e.data = u_data[i];
    e.rob  = u_rob[i];
    e.rd   = u_rd[i];
    sb.push_back(e);
  endtask

  task automatic expect_wb(input string tag);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=no_entry expected=scoreboard_entry", tag);
    end else begin
      last = sb.pop_front();
      check_output({tag, "_valid"}, 32'(bus.WB_out_valid), 32'd1);
      check_output({tag, "_data"}, bus.WB_out_data, last.data);
      check_output({tag, "_rob"}, 32'(bus.WB_out_rob_idx), 32'(last.rob));
      check_output({tag, "_rd"}, 32'(bus.WB_out_rd), 32'(last.rd));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    step();
    rst = 1'b0;
  endtask

  // A request that drops valid without having been consumed is a protocol error.
  always @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (|pending) begin
        checks++;
        assert (!(|(pending & ~bus.req_valid))) else begin
          errors++;
          $error("[TB] FAIL protocol_drop observed=%b expected=0000", pending & ~bus.req_valid);
        end
      end
      pending <= bus.req_valid & ~bus.req_ready;
    end
  end

  initial begin
    bus.req_data    = '0;
    bus.req_rob_idx = '0;
    bus.req_rd      = '0;
    set_defaults();

    $display("[TB] reset and idle");
    rst = 1'b1;
    apply_stimulus(4'b1111, 1'b1, 1'b0, 8'h00);
    check_output("rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    step();
    check_output("rst_valid", 32'(bus.WB_out_valid), 32'd0);
    check_output("rst_data", bus.WB_out_data, 32'd0);
    check_output("rst_rob", 32'(bus.WB_out_rob_idx), 32'd0);
    check_output("rst_rd", 32'(bus.WB_out_rd), 32'd0);
    check_output("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    check_output("rst_ready2", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    apply_stimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    step();
    check_output("idle_valid", 32'(bus.WB_out_valid), 32'd0);

    $display("[TB] single request");
    set_req(1, 32'hDEAD_BEEF, 3'd5, 7'd40);
    apply_stimulus(4'b0010, 1'b1, 1'b0, 8'h00);
    check_output("single_ready", 32'(bus.req_ready), 32'b0010);
    push_unit(1);
    step();
    expect_wb("single");
    apply_stimulus(4'b0000, 1'b1, 1'b0, 8'h00);
    step();
    check_output("single_drain", 32'(bus.WB_out_valid), 32'd0);

    $display("[TB] round robin");
    set_defaults();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(4'b1111, 1'b1, 1'b0, 8'h00);
      check_output("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      push_unit(k % 4);
      step();
      expect_wb("rr");
      check_output("rr_conflict", 32'(bus.conflict_cnt), 32'(k + 1));
    end

    $display("[TB] backpressure and starvation");
    do_reset();
    apply_stimulus(4'b1111, 1'b0, 1'b0, 8'h00);
    check_output("bp_first_ready", 32'(bus.req_ready), 32'b0001);
    push_unit(0);
    step();
    expect_wb("bp_first");
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(4'b1110, 1'b0, 1'b0, 8'h00);
      check_output("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      step();
      check_output("bp_hold_valid", 32'(bus.WB_out_valid), 32'd1);
      check_output("bp_hold_data", bus.WB_out_data, last.data);
    end
    check_output("bp_hold_conflict", 32'(bus.conflict_cnt), 32'd1);
    apply_stimulus(4'b1110, 1'b1, 1'b0, 8'h00);
    check_output("bp_release_ready", 32'(bus.req_ready), 32'b0010);
    push_unit(1);
    step();
    expect_wb("bp_release");
    check_output("bp_conflict", 32'(bus.conflict_cnt), 32'd2);

    $display("[TB] escalation ahead of round robin pointer");
    do_reset();
    apply_stimulus(4'b0100, 1'b0, 1'b0, 8'h00);
    check_output("esc_first_ready", 32'(bus.req_ready), 32'b0100);
    push_unit(2);
    step();
    expect_wb("esc_first");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(4'b1011, 1'b0, 1'b0, 8'h00);
      check_output("esc_hold_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    apply_stimulus(4'b1011, 1'b1, 1'b0, 8'h00);
    check_output("esc_ready", 32'(bus.req_ready), 32'b0001);
    push_unit(0);
    step();
    expect_wb("esc");

    $display("[TB] mispredict flush");
    do_reset();
    set_req(3, 32'hCAFE_0003, 3'd6, 7'd33);
    apply_stimulus(4'b1000, 1'b0, 1'b0, 8'h00);
    check_output("fl_load_ready", 32'(bus.req_ready), 32'b1000);
    push_unit(3);
    step();
    expect_wb("fl_load");
    set_req(2, 32'hF1F1_0002, 3'd3, 7'd22);
    apply_stimulus(4'b0100, 1'b0, 1'b1, 8'b0100_1000);
    check_output("fl_drain_ready", 32'(bus.req_ready), 32'b0100);
    step();
    check_output("fl_out_valid", 32'(bus.WB_out_valid), 32'd0);
    check_output("fl_keep_rob", 32'(bus.WB_out_rob_idx), 32'd6);
    check_output("fl_keep_data", bus.WB_out_data, 32'hCAFE_0003);
    apply_stimulus(4'b1000, 1'b0, 1'b0, 8'h00);
    check_output("fl_reload_ready", 32'(bus.req_ready), 32'b1000);
    push_unit(3);
    step();
    expect_wb("fl_reload");
    set_req(0, 32'h0BAD_F00D, 3'd1, 7'd11);
    apply_stimulus(4'b0101, 1'b0, 1'b1, 8'b0100_1000);
    check_output("fl_grant_ready", 32'(bus.req_ready), 32'b0101);
    push_unit(0);
    step();
    expect_wb("fl_grant");
    check_output("fl_conflict", 32'(bus.conflict_cnt), 32'd0);

    $display("[TB] reset mid-operation");
    set_defaults();
    rst = 1'b1;
    apply_stimulus(4'b1111, 1'b0, 1'b0, 8'h00);
    check_output("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;
    check_output("mid_rst_valid", 32'(bus.WB_out_valid), 32'd0);
    check_output("mid_rst_data", bus.WB_out_data, 32'd0);
    apply_stimulus(4'b1111, 1'b1, 1'b0, 8'h00);
    check_output("mid_rst_grant", 32'(bus.req_ready), 32'b0001);
    push_unit(0);
    step();
    expect_wb("mid_rst");

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
